// File: rtl/video_mem_arbiter.sv
// Arbitrates the single-port video RAM between the display read stream and queued pixel writes.
// Display reads always win; writes are buffered in a small FIFO and drained during blanking.
module video_mem_arbiter #(
    parameter int unsigned X_WIDTH    = 8,
    parameter int unsigned Y_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iDisplay,
    input  logic [X_WIDTH-1:0]         iVideoMemCol,
    input  logic [Y_WIDTH-1:0]         iVideoMemRow,
    input  logic                       iWrReq,
    input  logic [X_WIDTH-1:0]         iWrCol,
    input  logic [Y_WIDTH-1:0]         iWrRow,
    input  logic [DATA_WIDTH-1:0]      iWrData,
    output logic                       oWrAck,
    output logic [X_WIDTH+Y_WIDTH-1:0] oMemAddr,
    output logic                       oMemWriteEnable,
    output logic [DATA_WIDTH-1:0]      oMemWriteData,
    input  logic [DATA_WIDTH-1:0]      iMemReadData,
    output logic [DATA_WIDTH-1:0]      oPixelData,
    output logic                       oPixelValid,
    output logic [FIFO_AW:0]           oFifoCount
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   FullCount = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CntOne    = 1;
    localparam logic [FIFO_AW-1:0] PtrOne    = 1;

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e                       state_q;
    logic [FIFO_AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]             count_q, count_d;
    logic [Y_WIDTH-1:0]           row_mem [Depth];
    logic [X_WIDTH-1:0]           col_mem [Depth];
    logic [DATA_WIDTH-1:0]        data_mem [Depth];
    logic [X_WIDTH+Y_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]        wdata_q;
    logic                         d1_q;
    logic                         pix_valid_q;
    logic [DATA_WIDTH-1:0]        pix_data_q;
    logic                         push, pop;

    assign oWrAck = ~Reset & (count_q != FullCount);
    assign push   = iWrReq & oWrAck;
    // Display has priority: a drain cycle is dropped, not delayed, when iDisplay is high.
    assign pop    = ~Reset & ~iDisplay & (state_q == StWrite) & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (!push && pop) begin
            count_d = count_q - CntOne;
        end
    end

    // Address/data hold their last value when neither reading nor writing.
    always_comb begin
        oMemAddr        = addr_q;
        oMemWriteData   = wdata_q;
        oMemWriteEnable = 1'b0;
        if (iDisplay) begin
            oMemAddr = {iVideoMemRow, iVideoMemCol};
        end else if (pop) begin
            oMemAddr        = {row_mem[rd_ptr_q], col_mem[rd_ptr_q]};
            oMemWriteData   = data_mem[rd_ptr_q];
            oMemWriteEnable = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            row_mem[wr_ptr_q]  <= iWrRow;
            col_mem[wr_ptr_q]  <= iWrCol;
            data_mem[wr_ptr_q] <= iWrData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            d1_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Counting this cycle's push lets a blanking write issue on the next cycle.
                    if (iDisplay) begin
                        state_q <= StRead;
                    end else if (count_q != '0 || push) begin
                        state_q <= StWrite;
                    end
                end
                StRead: begin
                    if (!iDisplay) begin
                        state_q <= StIdle;
                    end
                end
                StWrite: begin
                    if (iDisplay) begin
                        state_q <= StRead;
                    end else if (count_d == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q     <= count_d;
            addr_q      <= oMemAddr;
            wdata_q     <= oMemWriteData;
            d1_q        <= iDisplay;
            pix_valid_q <= d1_q;
            pix_data_q  <= d1_q ? iMemReadData : '0;
        end
    end

    assign oPixelData  = pix_data_q;
    assign oPixelValid = pix_valid_q;
    assign oFifoCount  = count_q;

endmodule
